aes_mixcolumns: RTL and testbench

//  AES MixColumns round transform (FIPS-197 5.1.3), plus optional InvMixColumns (5.3.3).

---
 rtl/aes_mixcolumns.sv | 90 +++++++++
 tb/tb_aes_mixcolumns.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aes_mixcolumns.sv
// AES MixColumns / InvMixColumns round stage.
// One full 4x4 state per cycle, result registered one cycle later.
module aes_mixcolumns #(
   parameter bit INV_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       inv,
   input  logic [7:0] state_in  [4][4],
   output logic [7:0] state_out [4][4],
   output logic       out_valid
);

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // nxt[col][row]: combinational result feeding the output register
   logic [3:0][3:0][7:0] nxt;

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a  [4];
      logic [7:0] d2 [4];
      logic [7:0] fw [4];

      for (genvar r = 0; r < 4; r++) begin : g_row
         assign a[r]  = state_in[r][c];
         assign d2[r] = xt(a[r]);
      end

      assign fw[0] = d2[0] ^ d2[1] ^ a[1] ^ a[2] ^ a[3];
      assign fw[1] = a[0] ^ d2[1] ^ d2[2] ^ a[2] ^ a[3];
      assign fw[2] = a[0] ^ a[1] ^ d2[2] ^ d2[3] ^ a[3];
      assign fw[3] = d2[0] ^ a[0] ^ a[1] ^ a[2] ^ d2[3];

      if (INV_EN) begin : g_inv
         logic [7:0] d4 [4];
         logic [7:0] d8 [4];
         logic [7:0] m9 [4];
         logic [7:0] mb [4];
         logic [7:0] md [4];
         logic [7:0] me [4];
         logic [7:0] iv [4];

         for (genvar r = 0; r < 4; r++) begin : g_mul
            assign d4[r] = xt(d2[r]);
            assign d8[r] = xt(d4[r]);
            assign m9[r] = d8[r] ^ a[r];
            assign mb[r] = d8[r] ^ d2[r] ^ a[r];
            assign md[r] = d8[r] ^ d4[r] ^ a[r];
            assign me[r] = d8[r] ^ d4[r] ^ d2[r];
         end

         assign iv[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         assign iv[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         assign iv[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         assign iv[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

         for (genvar r = 0; r < 4; r++) begin : g_sel
            assign nxt[c][r] = inv ? iv[r] : fw[r];
         end
      end else begin : g_fwd
         for (genvar r = 0; r < 4; r++) begin : g_sel
            assign nxt[c][r] = fw[r];
         end
      end
   end

   if (!INV_EN) begin : g_no_inv
      logic unused_inv;
      assign unused_inv = inv;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               state_out[r][c] <= 8'h00;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++)
                  state_out[r][c] <= nxt[c][r];
      end
   end

endmodule

// File: tb/tb_aes_mixcolumns.sv
// Directed bench for aes_mixcolumns.
// States are handled packed row-major: byte (r,c) at bits 127-8*(4r+c).
module tb_aes_mixcolumns;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       inv;
   logic [7:0] state_in  [4][4];
   logic [7:0] state_out [4][4];
   logic       out_valid;

   logic [127:0] in_p;
   logic [127:0] out_p;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   aes_mixcolumns #(.INV_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inv       (inv),
      .state_in  (state_in),
      .state_out (state_out),
      .out_valid (out_valid)
   );

   always_comb begin
      out_p = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            state_in[r][c] = in_p[127-8*(4*r+c) -: 8];
            out_p[127-8*(4*r+c) -: 8] = state_out[r][c];
         end
   end

   // Generic shift-and-add GF(2^8) multiply, polynomial 0x11B
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = x;
      logic [7:0] bb = y;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] coef(input int j, input bit i);
      case (j)
         0: return i ? 8'h0e : 8'h02;
         1: return i ? 8'h0b : 8'h03;
         2: return i ? 8'h0d : 8'h01;
         default: return i ? 8'h09 : 8'h01;
      endcase
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input bit i);
      logic [127:0] o = '0;
      logic [7:0] acc;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc ^= gmul(s[127-8*(4*k+c) -: 8], coef((k - r + 4) % 4, i));
            o[127-8*(4*r+c) -: 8] = acc;
         end
      return o;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic send(input logic [127:0] s, input logic i);
      in_p = s;
      inv = i;
      in_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   localparam logic [127:0] APPB_IN  = 128'hd4e0b81e_bfb44127_5d521198_30aef1e5;
   localparam logic [127:0] APPB_OUT = 128'h04e04828_66cbf806_8119d326_e59a7a4c;
   localparam logic [127:0] ZEROS    = 128'h0;
   localparam logic [127:0] ONES     = {128{1'b1}};
   localparam logic [127:0] CHK_IN   = 128'h55aa55aa_aa55aa55_55aa55aa_aa55aa55;
   localparam logic [127:0] CHK_OUT  = 128'hb04fb04f_4fb04fb0_b04fb04f_4fb04fb0;
   localparam logic [127:0] V5_IN    = 128'h639fba0c_53ca70cd_01020304_e4d78010;
   localparam logic [127:0] COL_IN   = 128'hdb000000_13000000_53000000_45000000;
   localparam logic [127:0] COL_OUT  = 128'h8e000000_4d000000_a1000000_bc000000;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      inv = 1'b0;
      in_p = ONES;
      #3;
      check("reset_state", out_p, ZEROS);
      check("reset_valid", {127'b0, out_valid}, 128'd1 - 128'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_valid", {127'b0, out_valid}, 128'd0);

      send(APPB_IN, 1'b0);
      check("appb_fwd", out_p, APPB_OUT);
      check("appb_valid", {127'b0, out_valid}, 128'd1);
      send(COL_IN, 1'b0);
      check("col_db135345", out_p, COL_OUT);

      // Back-to-back stream of five states
      send(APPB_IN, 1'b0);
      check("s0_appb", out_p, APPB_OUT);
      send(ZEROS, 1'b0);
      check("s1_zero", out_p, ZEROS);
      send(ONES, 1'b0);
      check("s2_ones", out_p, ONES);
      send(CHK_IN, 1'b0);
      check("s3_checker", out_p, CHK_OUT);
      check("s3_model", out_p, model(CHK_IN, 1'b0));
      check("s3_byte00", {120'b0, state_out[0][0]}, 128'hb0);
      send(V5_IN, 1'b0);
      check("s4_v5", out_p, model(V5_IN, 1'b0));
      check("s4_valid", {127'b0, out_valid}, 128'd1);

      idle();
      check("gap_valid", {127'b0, out_valid}, 128'd0);
      check("gap_hold", out_p, model(V5_IN, 1'b0));
      idle();
      check("gap_hold2", out_p, model(V5_IN, 1'b0));

      send(ZEROS, 1'b1);
      check("inv_zero", out_p, ZEROS);
      send(ONES, 1'b1);
      check("inv_ones", out_p, ONES);
      send(APPB_OUT, 1'b1);
      check("round_trip", out_p, APPB_IN);
      send(COL_OUT, 1'b1);
      check("inv_col", out_p, COL_IN);
      send(V5_IN, 1'b1);
      check("inv_v5", out_p, model(V5_IN, 1'b1));
      send(model(V5_IN, 1'b0), 1'b1);
      check("rt_v5", out_p, V5_IN);

      // Reset between edges while streaming
      in_p = CHK_IN;
      inv = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_state", out_p, ZEROS);
      check("mid_rst_valid", {127'b0, out_valid}, 128'd0);
      @(negedge clk);
      check("rst_held", out_p, ZEROS);
      rst = 1'b0;
      send(APPB_IN, 1'b0);
      check("post_rst", out_p, APPB_OUT);
      check("post_rst_valid", {127'b0, out_valid}, 128'd1);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
